// File: rtl/mips_pkg.sv
// Shared fetch-stage types: FSM encoding, PC constants, output slot payload.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DFLT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP       = 32'd4;

  // Payload carried by the one-entry output slot
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } slot_t;

  // A PC is unusable if it is not word-aligned or points past the imem depth
  function automatic logic pc_bad(input logic [31:0] pc, input int aw);
    return (pc[1:0] != 2'b00) || ((pc >> (aw + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/fetch_slot.sv
// One-entry valid/ready output register: flush beats load, load beats drain.
module fetch_slot
  import mips_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  logic  flush,
  input  logic  ready,
  input  slot_t d,
  output logic  valid,
  output slot_t q
);

  // Slot state: flush empties, load fills, a handshake without refill empties
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, FSM, range check, handshake counter, output slot.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DFLT,
  parameter int          IMEM_AW  = 6
) (
  input  logic               clk,
  input  logic               reset,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rd,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        instr,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_pc4,
  output logic               fault,
  output logic [31:0]        fetch_count
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic         slot_free, cur_bad, redir_bad;
  logic         load, flush;
  slot_t        slot_d, slot_q;

  assign imem_addr = pc[IMEM_AW+1:2];
  assign slot_free = !out_valid || out_ready;
  assign cur_bad   = pc_bad(pc, IMEM_AW);
  assign redir_bad = (redirect_pc[1:0] != 2'b00);
  assign fault     = (state == FAULT);

  assign slot_d  = '{instr: imem_rd, pc: pc, pc4: pc + PC_STEP};
  assign instr   = slot_q.instr;
  assign out_pc  = slot_q.pc;
  assign out_pc4 = slot_q.pc4;

  // Slot control: redirect flushes, a bad PC flushes, otherwise capture when free
  always_comb begin
    load  = 1'b0;
    flush = 1'b0;
    if (state == FETCH) begin
      if (redirect_valid)  flush = 1'b1;
      else if (slot_free) begin
        if (cur_bad) flush = 1'b1;
        else         load  = 1'b1;
      end
    end
  end

  // FSM and PC: redirect has priority, PC advances only on a capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      case (state)
        IDLE:  state <= FETCH;
        FETCH: begin
          if (redirect_valid) begin
            if (redir_bad) state <= FAULT;
            else           pc    <= redirect_pc;
          end else if (slot_free) begin
            if (cur_bad) state <= FAULT;
            else         pc    <= pc + PC_STEP;
          end
        end
        FAULT:   state <= FAULT;
        default: state <= FAULT;
      endcase
    end
  end

  // Handshake counter, live in every state, wraps naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      fetch_count <= '0;
    else if (out_valid && out_ready) fetch_count <= fetch_count + 32'd1;
  end

  fetch_slot u_slot (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .flush (flush),
    .ready (out_ready),
    .d     (slot_d),
    .valid (out_valid),
    .q     (slot_q)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized run against a model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  imem_addr;
  logic [31:0] imem_rd;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] instr, out_pc, out_pc4, fetch_count;
  logic        fault;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [64];
  assign imem_rd = mem[imem_addr];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0), .IMEM_AW(6)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
    .out_pc(out_pc), .out_pc4(out_pc4), .fault(fault), .fetch_count(fetch_count)
  );

  // behavioural model state
  bit          m_run, m_fault, m_v;
  logic [31:0] m_pc, m_instr, m_opc, m_opc4, m_cnt;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic hold_reset();
    reset = 1'b0;
    redirect_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr got=%h exp=0", instr); end
    checks++; if (out_pc !== 32'h0 || out_pc4 !== 32'h0) begin errors++; $display("FAIL rst_pc got=%h/%h exp=0/0", out_pc, out_pc4); end
    checks++; if (fault !== 1'b0 || fetch_count !== 32'h0) begin errors++; $display("FAIL rst_flt_cnt got=%b/%0d exp=0/0", fault, fetch_count); end
    checks++; if (imem_addr !== 6'd0) begin errors++; $display("FAIL rst_addr got=%0d exp=0", imem_addr); end
  endtask

  task automatic test_startup();
    out_ready = 1'b1;
    hold_reset();
    checks++; if (imem_addr !== 6'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL idle got addr=%0d v=%b exp 0/0", imem_addr, out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_nocap got v=%b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || instr !== 32'h20020005 || out_pc !== 32'h0 || out_pc4 !== 32'h4) begin
      errors++; $display("FAIL first_fetch got v=%b i=%h pc=%h pc4=%h exp 1/20020005/0/4", out_valid, instr, out_pc, out_pc4); end
    tick();
    checks++; if (out_valid !== 1'b1 || instr !== 32'h2003000c || out_pc !== 32'h4 || out_pc4 !== 32'h8) begin
      errors++; $display("FAIL second_fetch got v=%b i=%h pc=%h pc4=%h exp 1/2003000c/4/8", out_valid, instr, out_pc, out_pc4); end
  endtask

  task automatic test_stall();
    logic [31:0] si, sp, sc;
    logic [5:0]  sa;
    out_ready = 1'b1;
    hold_reset();
    tick(); tick();
    out_ready = 1'b0;
    si = instr; sp = out_pc; sa = imem_addr; sc = fetch_count;
    repeat (4) begin
      tick();
      checks++; if (instr !== si || out_pc !== sp || imem_addr !== sa || fetch_count !== sc || out_valid !== 1'b1) begin
        errors++; $display("FAIL stall got i=%h pc=%h a=%0d c=%0d exp i=%h pc=%h a=%0d c=%0d", instr, out_pc, imem_addr, fetch_count, si, sp, sa, sc); end
    end
    out_ready = 1'b1;
    tick();
    checks++; if (out_pc !== 32'h4 || out_valid !== 1'b1 || fetch_count !== 32'd1) begin
      errors++; $display("FAIL resume got pc=%h v=%b c=%0d exp 4/1/1", out_pc, out_valid, fetch_count); end
  endtask

  task automatic test_redirect();
    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h44;
    tick();
    redirect_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || imem_addr !== 6'd17) begin errors++; $display("FAIL redir_flush got v=%b a=%0d exp 0/17", out_valid, imem_addr); end
    tick();
    checks++; if (out_valid !== 1'b1 || instr !== 32'hac020054 || out_pc !== 32'h44) begin
      errors++; $display("FAIL redir_fetch got v=%b i=%h pc=%h exp 1/ac020054/44", out_valid, instr, out_pc); end
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1; redirect_pc = 32'h46;
    tick();
    checks++; if (fault !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mis_fault got f=%b v=%b exp 1/0", fault, out_valid); end
    for (int i = 0; i < 6; i++) begin
      redirect_valid = $urandom_range(0, 1); redirect_pc = $urandom_range(0, 63) << 2;
      out_ready = $urandom_range(0, 1);
      tick();
      checks++; if (fault !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL fault_sticky got f=%b v=%b exp 1/0", fault, out_valid); end
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_range_end();
    logic [31:0] seen [$];
    int hs = 0;
    out_ready = 1'b1;
    hold_reset();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'hF8;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid && out_ready) begin hs++; seen.push_back(out_pc); end
      tick();
    end
    checks++; if (seen.size() != 2) begin errors++; $display("FAIL end_count got=%0d exp=2", seen.size()); end
    else begin
      checks++; if (seen[0] !== 32'hF8 || seen[1] !== 32'hFC) begin errors++; $display("FAIL end_pcs got %h,%h exp f8,fc", seen[0], seen[1]); end
    end
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL end_fault got=%b exp=1", fault); end
    checks++; if (fetch_count !== 32'(hs)) begin errors++; $display("FAIL end_hs got=%0d exp=%0d", fetch_count, hs); end
  endtask

  task automatic test_reset_in_stall();
    out_ready = 1'b1;
    hold_reset();
    tick(); tick(); tick();
    out_ready = 1'b0;
    tick(); tick();
    #2 reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || instr !== 32'h0 || out_pc !== 32'h0 || out_pc4 !== 32'h0 ||
                  fault !== 1'b0 || fetch_count !== 32'h0 || imem_addr !== 6'd0) begin
      errors++; $display("FAIL async_rst got v=%b i=%h pc=%h pc4=%h f=%b c=%0d a=%0d exp all 0",
                         out_valid, instr, out_pc, out_pc4, fault, fetch_count, imem_addr); end
    test_startup();
  endtask

  // Model step: sample inputs before the edge, apply fetch rules after it
  task automatic model_tick();
    bit          rv, rdy, hs;
    logic [31:0] rp, w;
    rv = redirect_valid; rp = redirect_pc; rdy = out_ready;
    w  = mem[(m_pc >> 2) & 32'd63];
    tick();
    hs = m_v && rdy;
    if (!m_run) m_run = 1;
    else if (!m_fault) begin
      if (rv) begin
        m_v = 0;
        if (rp % 4 != 0) m_fault = 1; else m_pc = rp;
      end else if (!m_v || rdy) begin
        if (m_pc % 4 != 0 || m_pc >= 32'd256) begin m_fault = 1; m_v = 0; end
        else begin m_instr = w; m_opc = m_pc; m_opc4 = m_pc + 4; m_v = 1; m_pc = m_pc + 4; end
      end
    end else if (hs) m_v = 0;
    if (hs) m_cnt = m_cnt + 1;
  endtask

  task automatic test_random();
    int r;
    for (int ep = 0; ep < 4; ep++) begin
      hold_reset();
      m_run = 0; m_fault = 0; m_v = 0; m_pc = 0; m_instr = 0; m_opc = 0; m_opc4 = 0; m_cnt = 0;
      for (int c = 0; c < 150; c++) begin
        out_ready = ($urandom_range(0, 3) != 0);
        redirect_valid = ($urandom_range(0, 15) == 0);
        r = $urandom_range(0, 63);
        if (r == 0)      redirect_pc = $urandom | 32'h1;
        else if (r == 1) redirect_pc = 32'h100 + ($urandom_range(0, 15) << 2);
        else             redirect_pc = $urandom_range(0, 63) << 2;
        model_tick();
        checks++;
        if (out_valid !== m_v || fault !== m_fault || fetch_count !== m_cnt ||
            imem_addr !== 6'(m_pc >> 2) || instr !== m_instr || out_pc !== m_opc || out_pc4 !== m_opc4) begin
          errors++;
          $display("FAIL rand ep=%0d c=%0d got v=%b f=%b n=%0d a=%0d i=%h pc=%h pc4=%h exp v=%b f=%b n=%0d a=%0d i=%h pc=%h pc4=%h",
                   ep, c, out_valid, fault, fetch_count, imem_addr, instr, out_pc, out_pc4,
                   m_v, m_fault, m_cnt, 6'(m_pc >> 2), m_instr, m_opc, m_opc4);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0]  = 32'h20020005;
    mem[1]  = 32'h2003000c;
    mem[17] = 32'hac020054;
    test_reset();
    test_startup();
    test_stall();
    test_redirect();
    test_misaligned();
    test_range_end();
    test_reset_in_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
